// File: rtl/timer_cmd_tx.sv
// Transmit side of the serial timer command protocol: serializes PATTERN then a
// delay value MSB-first, then waits (with a watchdog) for timer_done and acks it.
module timer_cmd_tx #(
    parameter logic [3:0] PATTERN     = 4'b1101,
    parameter int         DELAY_W     = 4,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [DELAY_W-1:0] cmd_delay,
    output logic               cmd_ready,
    output logic               data,
    input  logic               timer_done,
    output logic               ack,
    output logic               busy,
    output logic               timeout_err,
    output logic [7:0]         frame_cnt
);

    localparam int FW    = 4 + DELAY_W;
    localparam int IDX_W = $clog2(FW + 1);
    localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_PRE = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(FW);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        WAIT_DONE,
        ACK
    } state_t;

    state_t            state;
    logic [FW-1:0]     shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [WD_W-1:0]   wd_cnt;

    // Both are pure decodes of the state register, so no input reaches them.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            wd_cnt      <= '0;
            data        <= 1'b0;
            ack         <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            ack         <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    data <= 1'b0;
                    if (cmd_valid) begin
                        // First pattern bit goes out on the accept edge; the rest queue behind it.
                        data    <= PATTERN[3];
                        shreg   <= {PATTERN[2:0], cmd_delay, 1'b0};
                        bit_idx <= IDX_W'(1);
                        state   <= PREAMBLE;
                    end
                end
                PREAMBLE, PAYLOAD: begin
                    if (bit_idx == IDX_END) begin
                        data   <= 1'b0;
                        wd_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else begin
                        data    <= shreg[FW-1];
                        shreg   <= {shreg[FW-2:0], 1'b0};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_PRE) begin
                            state <= PAYLOAD;
                        end
                    end
                end
                WAIT_DONE: begin
                    data <= 1'b0;
                    // timer_done is checked first so it wins over an expiring watchdog.
                    if (timer_done) begin
                        ack       <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= ACK;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ACK: begin
                    data  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    data  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cmd_tx.sv
// Bench for timer_cmd_tx: queue-based frame model compared every cycle, plus
// directed checks with hand-computed expectations.
module tb_timer_cmd_tx;

    localparam int         DW  = 4;
    localparam int         T   = 50;
    localparam logic [3:0] PAT = 4'b1101;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [DW-1:0] cmd_delay;
    logic          cmd_ready;
    logic          data;
    logic          timer_done;
    logic          ack;
    logic          busy;
    logic          timeout_err;
    logic [7:0]    frame_cnt;

    timer_cmd_tx #(.PATTERN(PAT), .DELAY_W(DW), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_delay(cmd_delay),
        .cmd_ready(cmd_ready), .data(data), .timer_done(timer_done), .ack(ack),
        .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_seen = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference model: a queue of bits still to be serialized, a wait counter
    // and the expected output values for the current cycle.
    bit         mq[$];
    logic       e_data, e_ack, e_to, e_ready, e_busy;
    logic [7:0] e_cnt;
    bit         sending, in_wait;
    int         wcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            e_data = 0; e_ack = 0; e_to = 0; e_ready = 1; e_busy = 0; e_cnt = 0;
            sending = 0; in_wait = 0; wcnt = 0;
        end else begin
            e_ack = 0;
            e_to  = 0;
            if (e_ready) begin
                e_data = 0;
                if (cmd_valid) begin
                    for (int i = 3; i >= 0; i--) mq.push_back(PAT[i]);
                    for (int i = DW - 1; i >= 0; i--) mq.push_back(cmd_delay[i]);
                    e_data  = mq.pop_front();
                    sending = 1;
                    e_ready = 0;
                    e_busy  = 1;
                end
            end else if (sending) begin
                if (mq.size() > 0) begin
                    e_data = mq.pop_front();
                end else begin
                    e_data  = 0;
                    sending = 0;
                    in_wait = 1;
                    wcnt    = 0;
                end
            end else if (in_wait) begin
                if (timer_done) begin
                    in_wait = 0;
                    e_ack   = 1;
                    e_cnt   = e_cnt + 8'd1;
                end else if (wcnt == T - 1) begin
                    in_wait = 0;
                    e_to    = 1;
                    e_ready = 1;
                    e_busy  = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                e_ready = 1;
                e_busy  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (ack) ack_seen++;
        if (chk_en && !reset) begin
            n_tests++;
            if ({data, ack, timeout_err, cmd_ready, busy, frame_cnt} !==
                {e_data, e_ack, e_to, e_ready, e_busy, e_cnt}) begin
                n_fail++;
                $display("FAIL cycle_model at %0t: dut data=%b ack=%b to=%b rdy=%b busy=%b cnt=%0d, model data=%b ack=%b to=%b rdy=%b busy=%b cnt=%0d",
                         $time, data, ack, timeout_err, cmd_ready, busy, frame_cnt,
                         e_data, e_ack, e_to, e_ready, e_busy, e_cnt);
            end
        end
    end

    // Returns at the negedge of the first frame cycle (k+1).
    task automatic send(input logic [DW-1:0] d);
        int w;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_delay = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic capture(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], data};
            if (i < 7) @(negedge clk);
        end
    endtask

    logic [7:0]    bits;
    logic [DW-1:0] rd;
    int            n, a0;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_delay = '0; timer_done = 1'b0;
        #12;
        check("reset_data",  32'(data),        32'd0);
        check("reset_ready", 32'(cmd_ready),   32'd1);
        check("reset_busy",  32'(busy),        32'd0);
        check("reset_ack",   32'(ack),         32'd0);
        check("reset_to",    32'(timeout_err), 32'd0);
        check("reset_cnt",   32'(frame_cnt),   32'd0);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Basic frame 0101 and ack after a 30-cycle wait
        send(4'b0101);
        check("busy_k1",  32'(busy),      32'd1);
        check("ready_k1", 32'(cmd_ready), 32'd0);
        capture(bits);
        check("frame_0101", 32'(bits), 32'(8'b11010101));
        @(negedge clk);
        check("data_idle_after", 32'(data), 32'd0);
        repeat (29) @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        check("ack_pulse", 32'(ack),       32'd1);
        check("cnt_1",     32'(frame_cnt), 32'd1);
        @(negedge clk);
        check("ack_one_cycle", 32'(ack),       32'd0);
        check("ready_after",   32'(cmd_ready), 32'd1);
        a0 = ack_seen;
        repeat (5) @(negedge clk);
        check("no_second_ack", 32'(ack_seen - a0), 32'd0);
        timer_done = 1'b0;

        // Watchdog expiry
        send(4'hF);
        capture(bits);
        check("frame_F", 32'(bits), 32'(8'b11011111));
        @(negedge clk);
        n = 0;
        while (!timeout_err && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n),         32'd50);
        check("timeout_ready",   32'(cmd_ready), 32'd1);
        check("timeout_cnt",     32'(frame_cnt), 32'd1);
        @(negedge clk);
        check("timeout_once", 32'(timeout_err), 32'd0);

        // timer_done on the last watchdog cycle wins
        send(4'hF);
        capture(bits);
        @(negedge clk);
        repeat (49) @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        check("done49_ack", 32'(ack),         32'd1);
        check("done49_to",  32'(timeout_err), 32'd0);
        check("done49_cnt", 32'(frame_cnt),   32'd2);
        @(negedge clk);
        check("done49_no_late_to", 32'(timeout_err), 32'd0);

        // timer_done in IDLE/PREAMBLE and cmd changes mid-frame are ignored
        a0 = ack_seen;
        timer_done = 1'b1;
        repeat (3) @(negedge clk);
        timer_done = 1'b0;
        send(4'b0011);
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits = {bits[6:0], data};
            if (i == 1) timer_done = 1'b1;
            if (i == 2) timer_done = 1'b0;
            if (i == 3) begin cmd_valid = 1'b1; cmd_delay = 4'b1100; end
            if (i == 5) cmd_valid = 1'b0;
            if (i < 7) @(negedge clk);
        end
        check("frame_ignore",   32'(bits),           32'(8'b11010011));
        check("ignored_done",   32'(ack_seen - a0),  32'd0);
        @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        check("ignore_ack", 32'(ack),       32'd1);
        check("ignore_cnt", 32'(frame_cnt), 32'd3);
        @(negedge clk);

        // Asynchronous reset in the middle of the payload
        send(4'b1111);
        repeat (4) @(negedge clk);
        check("pre_reset_d3", 32'(data), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_data",  32'(data),      32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_ack",   32'(ack),       32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_cnt",   32'(frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send(4'b1001);
        capture(bits);
        check("frame_after_reset", 32'(bits), 32'(8'b11011001));
        @(negedge clk);
        timer_done = 1'b1;
        @(negedge clk);
        timer_done = 1'b0;
        check("post_reset_ack", 32'(ack),       32'd1);
        check("post_reset_cnt", 32'(frame_cnt), 32'd1);

        // 256 random frames, frame_cnt must wrap back to 0
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 256; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rd = DW'($urandom);
            send(rd);
            capture(bits);
            check("rand_frame", 32'(bits), 32'({PAT, rd}));
            @(negedge clk);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            timer_done = 1'b1;
            @(negedge clk);
            timer_done = 1'b0;
            check("rand_ack", 32'(ack),       32'd1);
            check("rand_cnt", 32'(frame_cnt), 32'((f + 1) % 256));
        end
        check("wrap_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
